// File: rtl/pll_rs_reset_seq_if.sv
`timescale 1ns/1ps
// Signal bundle between the PLL reset sequencer and the PLL / downstream domains.
// relock_cnt exists only when PLL_RS_LOCK_STATS_EN is defined.
interface pll_rs_reset_seq_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   pll_locked;
    logic                   sw_reset_req;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   ready;
    logic                   timeout_err;
    logic [2:0]             seq_state;
`ifdef PLL_RS_LOCK_STATS_EN
    logic [7:0]             relock_cnt;

    modport master (
        input  pll_locked, sw_reset_req,
        output pll_rst, dom_rst_n, ready, timeout_err, seq_state, relock_cnt
    );

    modport slave (
        output pll_locked, sw_reset_req,
        input  pll_rst, dom_rst_n, ready, timeout_err, seq_state, relock_cnt
    );
`else
    modport master (
        input  pll_locked, sw_reset_req,
        output pll_rst, dom_rst_n, ready, timeout_err, seq_state
    );

    modport slave (
        output pll_locked, sw_reset_req,
        input  pll_rst, dom_rst_n, ready, timeout_err, seq_state
    );
`endif
endinterface

// File: rtl/pll_rs_reset_seq.sv
`timescale 1ns/1ps
// PLL supervisor and staggered reset sequencer for the reed_solomon clocking subsystem.
// Define PLL_RS_LOCK_STATS_EN to add the saturating relock_cnt output.
module pll_rs_reset_seq #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_FILT      = 256,
    parameter int STAGGER        = 8
) (
    input logic                refclk,
    input logic                rst_n,
    pll_rs_reset_seq_if.master bus
);

    localparam int RST_W  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int WAIT_W = $clog2(LOCK_TIMEOUT);
    localparam int FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS + 1);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_DONE  = IDX_W'(NUM_DOMAINS);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   timeout_q, timeout_d;
    logic                   abort;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync;

    // pll_locked comes from another clock domain; only the last flop is ever looked at.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PLL_RST;
            rst_cnt_q  <= '0;
            wait_cnt_q <= '0;
            filt_cnt_q <= '0;
            stag_cnt_q <= '0;
            idx_q      <= '0;
            pll_rst_q  <= 1'b1;
            dom_q      <= '0;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            filt_cnt_q <= filt_cnt_d;
            stag_cnt_q <= stag_cnt_d;
            idx_q      <= idx_d;
            pll_rst_q  <= pll_rst_d;
            dom_q      <= dom_d;
            ready_q    <= ready_d;
            timeout_q  <= timeout_d;
        end
    end

    // Outputs are computed here as next-state values so every port leaves a flop.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        wait_cnt_d = wait_cnt_q;
        filt_cnt_d = filt_cnt_q;
        stag_cnt_d = stag_cnt_q;
        idx_d      = idx_q;
        pll_rst_d  = pll_rst_q;
        dom_d      = dom_q;
        ready_d    = ready_q;
        timeout_d  = timeout_q;
        abort      = 1'b0;

        case (state_q)
            S_PLL_RST: begin
                if (bus.sw_reset_req) begin
                    rst_cnt_d = '0;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    rst_cnt_d = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // Lock wins over a timeout expiring on the same edge.
                if (bus.sw_reset_req) begin
                    abort = 1'b1;
                end else if (locked_sync) begin
                    state_d    = S_FILTER;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_PLL_RST;
                    wait_cnt_d = '0;
                    pll_rst_d  = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_FILTER: begin
                if (bus.sw_reset_req) begin
                    abort = 1'b1;
                end else if (!locked_sync) begin
                    state_d    = S_WAIT_LOCK;
                    filt_cnt_d = '0;
                    wait_cnt_d = '0;
                end else if (filt_cnt_q == FILT_LAST) begin
                    state_d    = S_RELEASE;
                    filt_cnt_d = '0;
                end else begin
                    filt_cnt_d = filt_cnt_q + FILT_W'(1);
                end
            end
            S_RELEASE: begin
                if (bus.sw_reset_req || !locked_sync) begin
                    abort = 1'b1;
                end else if (idx_q == IDX_DONE) begin
                    state_d    = S_RUN;
                    ready_d    = 1'b1;
                    idx_d      = '0;
                    stag_cnt_d = '0;
                end else if (stag_cnt_q == STAG_LAST) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            dom_d[i] = 1'b1;
                        end
                    end
                    idx_d      = idx_q + IDX_W'(1);
                    stag_cnt_d = '0;
                end else begin
                    stag_cnt_d = stag_cnt_q + STAG_W'(1);
                end
            end
            S_RUN: begin
                if (bus.sw_reset_req || !locked_sync) begin
                    abort = 1'b1;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (abort) begin
            state_d    = S_PLL_RST;
            rst_cnt_d  = '0;
            wait_cnt_d = '0;
            filt_cnt_d = '0;
            stag_cnt_d = '0;
            idx_d      = '0;
            pll_rst_d  = 1'b1;
            dom_d      = '0;
            ready_d    = 1'b0;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.dom_rst_n   = dom_q;
    assign bus.ready       = ready_q;
    assign bus.timeout_err = timeout_q;
    assign bus.seq_state   = state_q;

`ifdef PLL_RS_LOCK_STATS_EN
    logic [7:0] relock_q;
    logic       loss_event;

    // A lock loss after release or a genuine timeout; a software request masks the timeout.
    assign loss_event = (((state_q == S_RELEASE) || (state_q == S_RUN)) && !locked_sync) ||
                        ((state_q == S_WAIT_LOCK) && !bus.sw_reset_req && !locked_sync &&
                         (wait_cnt_q == WAIT_LAST));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (loss_event && (relock_q != 8'hFF)) begin
            relock_q <= relock_q + 8'd1;
        end
    end

    assign bus.relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_pll_rs_reset_seq.sv
`timescale 1ns/1ps
// Directed self-checking bench for pll_rs_reset_seq with small parameters.
// Edge numbers count refclk rising edges after rst_n release.
module tb_pll_rs_reset_seq;

    logic refclk;
    logic rst_n;
    int   cur_edge;
    int   n_compared;
    int   n_mismatched;

    pll_rs_reset_seq_if #(.NUM_DOMAINS(3)) bus ();

    pll_rs_reset_seq #(
        .NUM_DOMAINS    (3),
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (8),
        .LOCK_TIMEOUT   (32),
        .LOCK_FILT      (4),
        .STAGGER        (2)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs mid-cycle, then run up to the given edge and settle 1ns past it.
    task automatic applyStimulus(input logic locked, input logic sw_req, input int until_edge);
        bus.pll_locked   = locked;
        bus.sw_reset_req = sw_req;
        while (cur_edge < until_edge) begin
            @(posedge refclk);
            cur_edge++;
        end
        #1;
    endtask

    task automatic releaseReset();
        @(posedge refclk);
        #3;
        rst_n    = 1'b1;
        cur_edge = 0;
    endtask

    task automatic assertResetAsync();
        #2;
        rst_n = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        cur_edge         = 0;
        rst_n            = 1'b1;
        bus.pll_locked   = 1'b1;
        bus.sw_reset_req = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge refclk);
        #2;
        checkOutput("rst_pll_rst", bus.pll_rst, 1);
        checkOutput("rst_dom", bus.dom_rst_n, 3'b000);
        checkOutput("rst_ready", bus.ready, 0);
        checkOutput("rst_timeout", bus.timeout_err, 0);
        checkOutput("rst_state", bus.seq_state, 0);
        releaseReset();

        // Nominal bring-up with lock present from the start
        applyStimulus(1, 0, 7);
        checkOutput("nom_pll_rst_e7", bus.pll_rst, 1);
        applyStimulus(1, 0, 8);
        checkOutput("nom_pll_rst_e8", bus.pll_rst, 0);
        checkOutput("nom_state_e8", bus.seq_state, 1);
        applyStimulus(1, 0, 9);
        checkOutput("nom_state_e9", bus.seq_state, 2);
        applyStimulus(1, 0, 12);
        checkOutput("nom_state_e12", bus.seq_state, 2);
        applyStimulus(1, 0, 13);
        checkOutput("nom_state_e13", bus.seq_state, 3);
        applyStimulus(1, 0, 14);
        checkOutput("nom_dom_e14", bus.dom_rst_n, 3'b000);
        applyStimulus(1, 0, 15);
        checkOutput("nom_dom_e15", bus.dom_rst_n, 3'b001);
        applyStimulus(1, 0, 16);
        checkOutput("nom_dom_e16", bus.dom_rst_n, 3'b001);
        applyStimulus(1, 0, 17);
        checkOutput("nom_dom_e17", bus.dom_rst_n, 3'b011);
        applyStimulus(1, 0, 19);
        checkOutput("nom_dom_e19", bus.dom_rst_n, 3'b111);
        checkOutput("nom_ready_e19", bus.ready, 0);
        applyStimulus(1, 0, 20);
        checkOutput("nom_ready_e20", bus.ready, 1);
        checkOutput("nom_state_e20", bus.seq_state, 4);
        applyStimulus(1, 0, 25);

        // Lock loss in S_RUN, then full replay
        applyStimulus(0, 0, 27);
        checkOutput("loss_ready_e27", bus.ready, 1);
        applyStimulus(0, 0, 28);
        checkOutput("loss_ready_e28", bus.ready, 0);
        checkOutput("loss_dom_e28", bus.dom_rst_n, 3'b000);
        checkOutput("loss_pll_rst_e28", bus.pll_rst, 1);
        checkOutput("loss_state_e28", bus.seq_state, 0);
        applyStimulus(1, 0, 35);
        checkOutput("replay_pll_rst_e35", bus.pll_rst, 1);
        applyStimulus(1, 0, 36);
        checkOutput("replay_pll_rst_e36", bus.pll_rst, 0);
        applyStimulus(1, 0, 47);
        checkOutput("replay_dom_e47", bus.dom_rst_n, 3'b111);
        checkOutput("replay_ready_e47", bus.ready, 0);
        applyStimulus(1, 0, 48);
        checkOutput("replay_ready_e48", bus.ready, 1);

        // Software request in S_RUN
        applyStimulus(1, 0, 50);
        applyStimulus(1, 1, 51);
        checkOutput("swrun_state_e51", bus.seq_state, 0);
        checkOutput("swrun_ready_e51", bus.ready, 0);
        checkOutput("swrun_dom_e51", bus.dom_rst_n, 3'b000);
        checkOutput("swrun_pll_rst_e51", bus.pll_rst, 1);
        applyStimulus(1, 0, 59);
        checkOutput("swrun_state_e59", bus.seq_state, 1);
        applyStimulus(1, 0, 60);
        checkOutput("glitch_state_e60", bus.seq_state, 2);

        // One-cycle lock glitch while filtering
        applyStimulus(0, 0, 61);
        applyStimulus(1, 0, 62);
        checkOutput("glitch_state_e62", bus.seq_state, 2);
        applyStimulus(1, 0, 63);
        checkOutput("glitch_state_e63", bus.seq_state, 1);
        applyStimulus(1, 0, 64);
        checkOutput("glitch_state_e64", bus.seq_state, 2);
        applyStimulus(1, 0, 67);
        checkOutput("glitch_state_e67", bus.seq_state, 2);
        checkOutput("glitch_dom_e67", bus.dom_rst_n, 3'b000);
        applyStimulus(1, 0, 68);
        checkOutput("glitch_state_e68", bus.seq_state, 3);
        applyStimulus(1, 0, 70);
        checkOutput("glitch_dom_e70", bus.dom_rst_n, 3'b001);

        // Software request in S_RELEASE with one domain out of reset
        applyStimulus(1, 1, 71);
        checkOutput("swrel_dom_e71", bus.dom_rst_n, 3'b000);
        checkOutput("swrel_state_e71", bus.seq_state, 0);
        checkOutput("swrel_pll_rst_e71", bus.pll_rst, 1);
        applyStimulus(1, 0, 76);
        applyStimulus(0, 0, 78);
        checkOutput("swrel_pll_rst_e78", bus.pll_rst, 1);
        applyStimulus(0, 0, 79);
        checkOutput("swrel_pll_rst_e79", bus.pll_rst, 0);

        // Lock never arrives: timeout and retry loop
        applyStimulus(0, 0, 110);
        checkOutput("to_state_e110", bus.seq_state, 1);
        checkOutput("to_err_e110", bus.timeout_err, 0);
        applyStimulus(0, 0, 111);
        checkOutput("to_err_e111", bus.timeout_err, 1);
        checkOutput("to_state_e111", bus.seq_state, 0);
        checkOutput("to_pll_rst_e111", bus.pll_rst, 1);
        applyStimulus(0, 0, 119);
        checkOutput("to_pll_rst_e119", bus.pll_rst, 0);
        applyStimulus(0, 0, 151);
        checkOutput("to2_state_e151", bus.seq_state, 0);
        checkOutput("to2_err_e151", bus.timeout_err, 1);
        checkOutput("to2_ready_e151", bus.ready, 0);

        // Software request while in S_PLL_RST restarts the pulse count
        applyStimulus(0, 0, 153);
        applyStimulus(0, 1, 154);
        applyStimulus(0, 0, 159);
        checkOutput("swpr_pll_rst_e159", bus.pll_rst, 1);
        applyStimulus(0, 0, 161);
        checkOutput("swpr_pll_rst_e161", bus.pll_rst, 1);
        applyStimulus(0, 0, 162);
        checkOutput("swpr_pll_rst_e162", bus.pll_rst, 0);

        assertResetAsync();
        checkOutput("arst1_pll_rst", bus.pll_rst, 1);
        checkOutput("arst1_timeout", bus.timeout_err, 0);
        checkOutput("arst1_state", bus.seq_state, 0);
        bus.pll_locked = 1'b0;
        releaseReset();

        // Lock lands on the same edge the timeout would expire
        applyStimulus(0, 0, 37);
        applyStimulus(1, 0, 39);
        checkOutput("tie_state_e39", bus.seq_state, 1);
        applyStimulus(1, 0, 40);
        checkOutput("tie_state_e40", bus.seq_state, 2);
        checkOutput("tie_err_e40", bus.timeout_err, 0);
        applyStimulus(1, 0, 51);
        checkOutput("tie_ready_e51", bus.ready, 1);
        checkOutput("tie_dom_e51", bus.dom_rst_n, 3'b111);

        assertResetAsync();
        checkOutput("arst2_dom", bus.dom_rst_n, 3'b000);
        checkOutput("arst2_ready", bus.ready, 0);
        checkOutput("arst2_pll_rst", bus.pll_rst, 1);
        checkOutput("arst2_state", bus.seq_state, 0);

`ifdef PLL_RS_LOCK_STATS_EN
        bus.pll_locked = 1'b1;
        releaseReset();
        applyStimulus(1, 0, 20);
        checkOutput("stats_ready_start", bus.ready, 1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, cur_edge + 3);
            if (i == 0) begin
                checkOutput("stats_cnt_first", bus.relock_cnt, 1);
            end
            applyStimulus(1, 0, cur_edge + 20);
        end
        checkOutput("stats_cnt_sat", bus.relock_cnt, 255);
        checkOutput("stats_ready_end", bus.ready, 1);
        assertResetAsync();
        checkOutput("stats_cnt_rst", bus.relock_cnt, 0);
        checkOutput("stats_ready_rst", bus.ready, 0);
        checkOutput("stats_dom_rst", bus.dom_rst_n, 3'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pll_rs_reset_seq.md
Name: pll_rs_reset_seq

Overview:
- Parametrised PLL supervisor and reset sequencer for the reed_solomon clocking subsystem; runs on the free-running PLL reference clock.
- Drives the PLL's active-high reset and watches its `locked` output, which is asynchronous to `refclk` and is therefore synchronised internally.
- Releases NUM_DOMAINS downstream synchronous resets in staggered order once lock is stable.
- Detects lock loss, lock timeout and software reset requests, and re-runs the full sequence on each.

Parameters:
- NUM_DOMAINS, 4: number of downstream reset outputs; 1..16.
- SYNC_STAGES, 2: synchroniser depth on pll_locked; 2..4.
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt; >=1.
- LOCK_TIMEOUT, 65536: cycles allowed in S_WAIT_LOCK before declaring timeout; >=2.
- LOCK_FILT, 256: consecutive locked cycles required before release; >=1.
- STAGGER, 8: cycles between successive domain releases; >=1.

Ports:
- refclk  in  1  reference clock; sole clock of the block.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised by the integrator.
- pll_locked  in  1  PLL lock indicator; asynchronous to refclk.
- sw_reset_req  in  1  single-cycle request to re-run the full sequence.
- pll_rst  out  1  active-high reset to the PLL.
- dom_rst_n  out  NUM_DOMAINS  per-domain active-low resets; index 0 is released first.
- ready  out  1  high when every domain is released and lock is held.
- timeout_err  out  1  sticky; set on any lock timeout, cleared only by rst_n.
- seq_state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset values (rst_n low):
  - pll_rst=1, dom_rst_n=all 0, ready=0, timeout_err=0.
  - State S_PLL_RST (seq_state=0); all counters 0; synchroniser flops 0.
- locked_sync is pll_locked delayed through SYNC_STAGES flops. All decisions below use locked_sync.
- S_PLL_RST (0):
  - pll_rst=1.
  - Counter increments every edge; the edge at which it reaches PLL_RST_CYCLES moves to S_WAIT_LOCK.
  - pll_rst=0 from that edge.
- S_WAIT_LOCK (1):
  - If locked_sync=1, next edge goes to S_FILTER.
  - Else, after LOCK_TIMEOUT cycles in this state: set timeout_err, return to S_PLL_RST, reload the counter.
- S_FILTER (2):
  - Counts consecutive cycles with locked_sync=1.
  - Any 0 returns to S_WAIT_LOCK with both the wait and filter counters cleared.
  - After LOCK_FILT counts, go to S_RELEASE.
- S_RELEASE (3):
  - Stagger counter runs; every STAGGER edges, dom_rst_n[idx] is set to 1 and idx increments.
  - After idx reaches NUM_DOMAINS, go to S_RUN on the next edge. ready=1 from that edge.
  - Released domains stay released while later ones are pending.
- S_RUN (4): ready=1; all dom_rst_n=1.
- Abort (any state except S_PLL_RST), triggered by locked_sync falling in S_RELEASE/S_RUN, or by sw_reset_req in any of states 1-4:
  - On the same edge: dom_rst_n=all 0, ready=0, pll_rst=1, state S_PLL_RST, counters cleared.
  - Lock loss in S_WAIT_LOCK is not an event.
- sw_reset_req while in S_PLL_RST: restarts the PLL_RST_CYCLES count.
- Simultaneous events on one edge:
  - Abort has priority over every progression.
  - A timeout and a lock arriving on the same edge counts as lock; timeout_err is not set.
- Counters are sized with $clog2 of their maximum value and never wrap; each is cleared on every state entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Mid-operation rst_n assertion returns every output to its reset value asynchronously.

Optional Feature:
- Macro: PLL_RS_LOCK_STATS_EN.
- When defined, adds output relock_cnt (8 bits):
  - Saturating count of lock-loss aborts from S_RELEASE/S_RUN plus lock timeouts; holds at 255.
  - Cleared only by rst_n.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Nominal sequence. Setup: NUM_DOMAINS=3, SYNC_STAGES=2, PLL_RST_CYCLES=8, LOCK_FILT=4, STAGGER=2; pll_locked=1 throughout; rst_n released before edge 1.
  - pll_rst falls at edge 8.
  - S_FILTER entered at edge 9.
  - dom_rst_n[0..2] rise at edges 15, 17, 19.
  - ready rises at edge 20.
- Lock glitch during filtering: pll_locked low for 1 cycle during S_FILTER -> FSM returns to S_WAIT_LOCK, filter count restarts, dom_rst_n stays 0; release completes LOCK_FILT counts after the final re-entry to S_FILTER.
- Timeout: LOCK_TIMEOUT=32, pll_locked held 0 -> timeout_err=1 after 8+32 edges; pll_rst re-pulses for 8 cycles; the retry loop repeats indefinitely; ready stays 0.
- Lock loss in S_RUN: drop pll_locked -> SYNC_STAGES edges later, ready=0, dom_rst_n=000 and pll_rst=1 on the same edge; the full sequence replays once lock returns.
- sw_reset_req during S_RELEASE with one domain released -> dom_rst_n=000 and state=0 on the next edge; with PLL_RST_CYCLES=8, pll_rst stays high 8 cycles.
- With PLL_RS_LOCK_STATS_EN defined: 300 lock-loss events -> relock_cnt=255; assert rst_n -> relock_cnt=0 and all outputs at reset values immediately (asynchronously).
